dmem_port_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single data-memory port (DataMem + MMIO via Mmu) among

---
 rtl/dmem_port_arbiter_pkg.sv | 28 ++
 rtl/dmem_port_arbiter_if.sv | 42 ++++
 rtl/dmem_port_arbiter_rr_pick.sv | 37 +++
 rtl/dmem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
//==============================================================================
// riswitch_bus_pkg : shared memOp encoding and arbiter state type
// Rev 1.0
//==============================================================================
`default_nettype none

package riswitch_bus_pkg;

    localparam int MEMOP_W = 3;

    typedef enum logic [MEMOP_W-1:0] {
        MOP_BYTE   = 3'd0,
        MOP_HALF   = 3'd1,
        MOP_WORD   = 3'd2,
        MOP_BYTE_U = 3'd4,
        MOP_HALF_U = 3'd5
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
//==============================================================================
// dmem_port_arbiter_if : requester-side and memory-side bus of the arbiter
// Rev 1.0
//==============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]                             req;
    logic [NREQ-1:0]                             lock;
    logic [NREQ-1:0]                             req_we;
    logic [NREQ*AW-1:0]                          req_addr;
    logic [NREQ*DW-1:0]                          req_din;
    logic [NREQ*riswitch_bus_pkg::MEMOP_W-1:0]   req_op;
    logic [NREQ-1:0]                             gnt;
    logic [NREQ-1:0]                             ack;
    logic [DW-1:0]                               rdata;
    logic [AW-1:0]                               mem_addr;
    logic [DW-1:0]                               mem_din;
    logic [riswitch_bus_pkg::MEMOP_W-1:0]        mem_op;
    logic                                        mem_we;
    logic                                        mem_re;
    logic [DW-1:0]                               mem_dout;

    // The arbiter side
    modport master (
        input  req, lock, req_we, req_addr, req_din, req_op, mem_dout,
        output gnt, ack, rdata, mem_addr, mem_din, mem_op, mem_we, mem_re
    );

    // Requesters plus memory
    modport slave (
        output req, lock, req_we, req_addr, req_din, req_op, mem_dout,
        input  gnt, ack, rdata, mem_addr, mem_din, mem_op, mem_we, mem_re
    );

endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter_rr_pick.sv
//==============================================================================
// rr_pick : rotate-priority encoder, first set request after ptr (mod NREQ)
// Rev 1.0
//==============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  wire logic [NREQ-1:0]  req_i,
    input  wire logic [PTR_W-1:0] ptr_i,
    output logic      [NREQ-1:0]  win_o,
    output logic      [PTR_W-1:0] win_idx_o,
    output logic                  any_o
);

    int idx;

    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                win_o[idx] = 1'b1;
                win_idx_o  = PTR_W'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
//==============================================================================
// dmem_port_arbiter : round-robin owner of the shared DataMem/MMIO port
// Rev 1.0
//==============================================================================
`default_nettype none

module dmem_port_arbiter
    import riswitch_bus_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  wire logic         clock,
    input  wire logic         reset,
    dmem_port_arbiter_if.master bus
);

    localparam int               PTR_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0]       WAIT_INIT  = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
    localparam logic [3:0]       BURST_LAST = 4'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_RST    = PTR_W'(NREQ - 1);

    arb_state_t       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    din_q, din_d;
    mem_op_t          op_q, op_d;
    logic             we_q, we_d;
    logic [2:0]       wait_q, wait_d;
    logic [3:0]       burst_q, burst_d;

    logic [NREQ-1:0]    w_win;
    logic [PTR_W-1:0]   w_win_idx;
    logic               w_any;
    logic               w_load;
    logic [PTR_W-1:0]   w_sel_idx;
    logic [AW-1:0]      w_addr_arr [NREQ];
    logic [DW-1:0]      w_din_arr  [NREQ];
    logic [MEMOP_W-1:0] w_op_arr   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_addr_arr[i] = bus.req_addr[i*AW +: AW];
        assign w_din_arr[i]  = bus.req_din[i*DW +: DW];
        assign w_op_arr[i]   = bus.req_op[i*MEMOP_W +: MEMOP_W];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i     (bus.req),
        .ptr_i     (rr_ptr_q),
        .win_o     (w_win),
        .win_idx_o (w_win_idx),
        .any_o     (w_any)
    );

    // New grants come from the picker; burst continuations reload the owner
    assign w_sel_idx = (state_q == IDLE) ? w_win_idx : owner_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        rdata_d  = '0;
        addr_d   = addr_q;
        din_d    = din_q;
        op_d     = op_q;
        we_d     = we_q;
        wait_d   = wait_q;
        burst_d  = burst_q;
        w_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_any) begin
                    gnt_d   = w_win;
                    owner_d = w_win_idx;
                    w_load  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q || RD_LAT == 0) begin
                    state_d = RESP;
                    ack_d   = gnt_q;
                    rdata_d = we_q ? '0 : bus.mem_dout;
                end else begin
                    state_d = WAIT;
                    wait_d  = WAIT_INIT;
                end
            end
            WAIT: begin
                if (wait_q == 3'd0) begin
                    state_d = RESP;
                    ack_d   = gnt_q;
                    rdata_d = bus.mem_dout;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            RESP: begin
                rr_ptr_d = owner_q;
                if (bus.req[owner_q] && bus.lock[owner_q] && (burst_q < BURST_LAST)) begin
                    burst_d = burst_q + 4'd1;
                    w_load  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    burst_d = '0;
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_load) begin
            addr_d = w_addr_arr[w_sel_idx];
            din_d  = w_din_arr[w_sel_idx];
            op_d   = mem_op_t'(w_op_arr[w_sel_idx]);
            we_d   = bus.req_we[w_sel_idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= PTR_RST;
            owner_q  <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            op_q     <= MOP_BYTE;
            we_q     <= 1'b0;
            wait_q   <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            op_q     <= op_d;
            we_q     <= we_d;
            wait_q   <= wait_d;
            burst_q  <= burst_d;
        end
    end

    // Strobes decode from state so an async reset removes them at once
    assign bus.mem_we   = (state_q == ISSUE) &&  we_q;
    assign bus.mem_re   = (state_q == ISSUE) && !we_q;
    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.mem_op   = op_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
//==============================================================================
// tb_dmem_port_arbiter : directed checks of grant order, timing and bursts
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_dmem_port_arbiter;
    import riswitch_bus_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic clock;
    logic reset;
    int   vecs;
    int   errs;

    dmem_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    dmem_port_arbiter #(
        .NREQ      (NREQ),
        .AW        (AW),
        .DW        (DW),
        .RD_LAT    (1),
        .MAX_BURST (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        reset = 1'b1;
        bus.req = '0; bus.lock = '0; bus.req_we = '0;
        bus.req_addr = '0; bus.req_din = '0; bus.req_op = '0;
        bus.mem_dout = 32'hAAAA_5555;
        step(); step();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_re", bus.mem_re, 0);
        chk("rst_addr", bus.mem_addr, 0);
        reset = 1'b0;

        // 1: reset in the middle of a read wait
        bus.req = 2'b01; bus.req_we = 2'b00;
        bus.req_addr[31:0] = 32'h0000_0040; bus.req_op[2:0] = MOP_WORD;
        step();
        chk("t1_issue_re", bus.mem_re, 1);
        step();
        chk("t1_wait_gnt", bus.gnt, 2'b01);
        chk("t1_wait_re", bus.mem_re, 0);
        #2 reset = 1'b1;
        #1;
        chk("t1_async_gnt", bus.gnt, 0);
        chk("t1_async_ack", bus.ack, 0);
        chk("t1_async_we", bus.mem_we, 0);
        chk("t1_async_re", bus.mem_re, 0);
        step();
        reset = 1'b0;
        step();
        chk("t1_regrant", bus.gnt, 2'b01);
        chk("t1_regrant_re", bus.mem_re, 1);
        step();
        step();
        chk("t1_ack", bus.ack, 2'b01);
        bus.req = 2'b00;
        step();

        // 2: single word write by requester 0
        bus.req = 2'b01; bus.req_we = 2'b01;
        bus.req_addr[31:0] = 32'h1000_0010; bus.req_din[31:0] = 32'hDEAD_BEEF;
        bus.req_op[2:0] = MOP_WORD;
        step();
        chk("t2_we", bus.mem_we, 1);
        chk("t2_re", bus.mem_re, 0);
        chk("t2_addr", bus.mem_addr, 32'h1000_0010);
        chk("t2_din", bus.mem_din, 32'hDEAD_BEEF);
        chk("t2_op", bus.mem_op, MOP_WORD);
        chk("t2_gnt", bus.gnt, 2'b01);
        chk("t2_noack", bus.ack, 0);
        bus.req_addr[31:0] = 32'hFFFF_0000;
        step();
        chk("t2_ack", bus.ack, 2'b01);
        chk("t2_rdata0", bus.rdata, 0);
        chk("t2_we_off", bus.mem_we, 0);
        chk("t2_addr_hold", bus.mem_addr, 32'h1000_0010);
        bus.req = 2'b00;
        step();
        chk("t2_idle_gnt", bus.gnt, 0);
        chk("t2_idle_ack", bus.ack, 0);

        // 3: read with one cycle of memory latency
        bus.req = 2'b01; bus.req_we = 2'b00;
        bus.req_addr[31:0] = 32'h0000_0020; bus.req_op[2:0] = MOP_HALF_U;
        bus.mem_dout = 32'h1234_5678;
        step();
        chk("t3_re", bus.mem_re, 1);
        chk("t3_op", bus.mem_op, MOP_HALF_U);
        step();
        chk("t3_wait_ack", bus.ack, 0);
        chk("t3_wait_addr", bus.mem_addr, 32'h0000_0020);
        step();
        chk("t3_ack", bus.ack, 2'b01);
        chk("t3_rdata", bus.rdata, 32'h1234_5678);
        bus.req = 2'b00;
        step();
        chk("t3_rdata_clr", bus.rdata, 0);

        // 4: requester 1 alone, then both held without lock
        bus.req = 2'b10; bus.req_we = 2'b11;
        bus.req_addr[63:32] = 32'h0000_0100;
        step();
        chk("t4_solo_gnt", bus.gnt, 2'b10);
        chk("t4_solo_addr", bus.mem_addr, 32'h0000_0100);
        step();
        chk("t4_solo_ack", bus.ack, 2'b10);
        bus.req = 2'b00;
        step();
        bus.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_gnt", bus.gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("t4_we", bus.mem_we, 1);
            step();
            chk("t4_ack", bus.ack, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
            chk("t4_idle", bus.gnt, 0);
        end
        bus.req = 2'b00;

        // 5: locked burst capped at four transfers, then rotation
        step();
        bus.req = 2'b11; bus.lock = 2'b01;
        for (int b = 0; b < 4; b++) begin
            step();
            chk("t5_burst_gnt", bus.gnt, 2'b01);
            chk("t5_burst_we", bus.mem_we, 1);
            step();
            chk("t5_burst_ack", bus.ack, 2'b01);
        end
        step();
        chk("t5_cap_idle", bus.gnt, 0);
        step();
        chk("t5_rot_gnt", bus.gnt, 2'b10);
        step();
        chk("t5_rot_ack", bus.ack, 2'b10);
        step();
        step();
        chk("t5_back_gnt", bus.gnt, 2'b01);
        step();
        chk("t5_back_ack", bus.ack, 2'b01);
        bus.req = 2'b00; bus.lock = 2'b00;
        step();

        // 6: request withdrawn during issue
        bus.req = 2'b01; bus.req_we = 2'b01;
        step();
        chk("t6_gnt", bus.gnt, 2'b01);
        bus.req = 2'b00;
        step();
        chk("t6_ack", bus.ack, 2'b01);
        step();
        chk("t6_idle_gnt", bus.gnt, 0);
        chk("t6_idle_ack", bus.ack, 0);
        step();
        chk("t6_stay_idle", bus.gnt, 0);
        chk("t6_no_we", bus.mem_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // Grant must stay one-hot or empty on every cycle
    always @(negedge clock) begin
        if (!reset) begin
            chk("onehot_gnt", {63'd0, $onehot0(bus.gnt)}, 1);
        end
    end

endmodule

`default_nettype wire
